// File: rtl/unified_mem_arbiter.sv
// Arbitrates the fetch port (IF) and data port (DM) onto one shared
// single-port memory. DM has fixed priority, limited by an anti-starvation
// burst counter. An ack timeout aborts the access and sets a sticky error.
module unified_mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_DM_BURST = 4,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          busy,
    output logic          bus_err
);

    localparam int SW = $clog2(MAX_DM_BURST + 1);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM
    } state_t;

    state_t        state;
    logic [SW-1:0] starveCnt;
    logic [TW-1:0] toCnt;
    logic          starveHit;
    logic          timeoutHit;

    // IF has waited through a full DM burst and must be served next
    assign starveHit  = if_req && (starveCnt == SW'(MAX_DM_BURST));
    assign timeoutHit = (toCnt == TW'(TIMEOUT_CYC - 1));

    // Arbitration FSM with registered memory-side and pipeline-side outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            starveCnt <= '0;
            toCnt     <= '0;
            busy      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                IDLE: begin
                    toCnt <= '0;
                    if (dm_req && !starveHit) begin
                        state     <= BUSY_DM;
                        busy      <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        if (!if_req) begin
                            starveCnt <= '0;
                        end else if (starveCnt != SW'(MAX_DM_BURST)) begin
                            starveCnt <= starveCnt + 1'b1;
                        end
                    end else if (if_req) begin
                        state     <= BUSY_IF;
                        busy      <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        starveCnt <= '0;
                    end else begin
                        starveCnt <= '0;
                    end
                end
                BUSY_IF: begin
                    if (mem_ack || timeoutHit) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        mem_req  <= 1'b0;
                        if_ready <= 1'b1;
                        if_rdata <= mem_ack ? mem_rdata : '0;
                        if (!mem_ack) begin
                            bus_err <= 1'b1;
                        end
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
                end
                BUSY_DM: begin
                    if (mem_ack || timeoutHit) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        mem_req  <= 1'b0;
                        dm_ready <= 1'b1;
                        if (!mem_we) begin
                            dm_rdata <= mem_ack ? mem_rdata : '0;
                        end
                        if (!mem_ack) begin
                            bus_err <= 1'b1;
                        end
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios followed
// by randomized requesters and a randomized memory, all compared each cycle
// against a behavioural model of the arbitration rules.
module tb_unified_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXB = 4;
    localparam int TO   = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic          busy;
    logic          bus_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .AW(AW), .DW(DW), .MAX_DM_BURST(MAXB), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .bus_err(bus_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // memory contents seen by the arbiter
    function automatic logic [DW-1:0] memTable(input logic [AW-1:0] a);
        if (a == 32'h0)   return 32'h00500093;
        if (a == 32'h100) return 32'hA5A5A5A5;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // memory responder: 0 = random delay, 1 = fixed delay, 2 = never ack
    int memMode   = 1;
    int fixDelay  = 0;
    int delayLeft = 0;
    bit inTxn     = 0;
    bit forceAck  = 0;

    always begin
        @(negedge clk);
        #1;
        mem_ack   = forceAck;
        mem_rdata = $urandom;
        if (!mem_req) begin
            inTxn = 0;
        end else begin
            if (!inTxn) begin
                inTxn = 1;
                if (memMode == 2)      delayLeft = 100000;
                else if (memMode == 1) delayLeft = fixDelay;
                else if ($urandom_range(0, 39) == 0) delayLeft = 100000;
                else                   delayLeft = $urandom_range(0, 3);
            end
            if (delayLeft == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = memTable(mem_addr);
                inTxn     = 0;
            end else begin
                delayLeft--;
            end
        end
    end

    // behavioural model: owner 0 = none, 1 = IF, 2 = DM
    int            mOwner = 0, mStreak = 0, mWait = 0;
    logic          mMemReq = 0, mMemWe = 0, mIfReady = 0, mDmReady = 0, mBusErr = 0;
    logic [AW-1:0] mMemAddr = '0;
    logic [DW-1:0] mMemWdata = '0, mIfRdata = '0, mDmRdata = '0;
    logic          ok;

    always begin
        @(posedge clk);
        if (!rst) begin
            mOwner = 0; mStreak = 0; mWait = 0;
            mMemReq = 0; mMemWe = 0; mMemAddr = '0; mMemWdata = '0;
            mIfRdata = '0; mDmRdata = '0; mIfReady = 0; mDmReady = 0; mBusErr = 0;
        end else begin
            mIfReady = 0;
            mDmReady = 0;
            if (mOwner == 0) begin
                mWait = 0;
                if (dm_req && !(if_req && mStreak == MAXB)) begin
                    mOwner = 2; mMemReq = 1; mMemWe = dm_we;
                    mMemAddr = dm_addr; mMemWdata = dm_wdata;
                    mStreak = if_req ? ((mStreak < MAXB) ? mStreak + 1 : MAXB) : 0;
                end else if (if_req) begin
                    mOwner = 1; mMemReq = 1; mMemWe = 0;
                    mMemAddr = if_addr; mStreak = 0;
                end else begin
                    mStreak = 0;
                end
            end else if (mem_ack || mWait == TO - 1) begin
                ok = mem_ack;
                mMemReq = 0;
                if (mOwner == 1) begin
                    mIfReady = 1;
                    mIfRdata = ok ? memTable(mMemAddr) : '0;
                end else begin
                    mDmReady = 1;
                    if (!mMemWe) mDmRdata = ok ? memTable(mMemAddr) : '0;
                end
                if (!ok) mBusErr = 1;
                mOwner = 0;
            end else begin
                mWait++;
            end
        end
        #1;
        chk("mem_req",   mem_req,   mMemReq);
        chk("mem_we",    mem_we,    mMemWe);
        chk("mem_addr",  mem_addr,  mMemAddr);
        chk("mem_wdata", mem_wdata, mMemWdata);
        chk("if_ready",  if_ready,  mIfReady);
        chk("dm_ready",  dm_ready,  mDmReady);
        chk("if_rdata",  if_rdata,  mIfRdata);
        chk("dm_rdata",  dm_rdata,  mDmRdata);
        chk("busy",      busy,      mOwner != 0);
        chk("bus_err",   bus_err,   mBusErr);
    end

    // grant order observer for the starvation scenario
    bit logGrants = 0;
    bit prevReq   = 0;
    int grantQ[$];

    always begin
        @(negedge clk);
        if (logGrants && mem_req && !prevReq)
            grantQ.push_back((mem_addr == 32'h400) ? 1 : 2);
        prevReq = mem_req;
    end

    initial begin
        // reset
        repeat (3) @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_rdata", {if_rdata, dm_rdata}, 0);
        rst = 1'b1;
        @(negedge clk);

        // single fetch, ack in the first mem_req cycle
        memMode = 1; fixDelay = 0;
        if_req = 1; if_addr = 32'h0;
        @(negedge clk);
        chk("t1_mem_req_c1", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        chk("t1_if_ready_c2", if_ready, 1);
        chk("t1_if_rdata", if_rdata, 32'h00500093);
        if_req = 0;
        @(negedge clk);
        chk("t1_busy_c3", busy, 0);
        chk("t1_if_ready_c3", if_ready, 0);

        // collision: DM load wins, IF follows after the IDLE cycle
        if_req = 1; if_addr = 32'h40;
        dm_req = 1; dm_we = 0; dm_addr = 32'h100;
        @(negedge clk);
        chk("t2_dm_addr", mem_addr, 32'h100);
        chk("t2_dm_we", mem_we, 0);
        @(negedge clk);
        chk("t2_dm_ready", dm_ready, 1);
        chk("t2_if_not_ready", if_ready, 0);
        chk("t2_dm_rdata", dm_rdata, 32'hA5A5A5A5);
        dm_req = 0;
        @(negedge clk);
        chk("t2_if_addr", mem_addr, 32'h40);
        chk("t2_if_memreq", mem_req, 1);
        @(negedge clk);
        chk("t2_if_ready", if_ready, 1);
        if_req = 0;
        @(negedge clk);

        // starvation: both held, back-to-back stores
        grantQ.delete();
        logGrants = 1;
        if_req = 1; if_addr = 32'h400;
        dm_req = 1; dm_we = 1; dm_addr = 32'h800; dm_wdata = 32'hCAFE0001;
        repeat (20) @(negedge clk);
        if_req = 0; dm_req = 0;
        logGrants = 0;
        repeat (4) @(negedge clk);
        chk("t3_grant_count_ge6", grantQ.size() >= 6, 1);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t3_grant%0d", i), grantQ[i], (i == 4) ? 1 : 2);
        chk("t3_dm_rdata_kept", dm_rdata, 32'hA5A5A5A5);

        // store with ack delayed 3 cycles
        fixDelay = 3;
        dm_req = 1; dm_we = 1; dm_addr = 32'h20; dm_wdata = 32'h12345678;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("t4_memreq_c%0d", i), mem_req, 1);
            chk($sformatf("t4_we_c%0d", i), mem_we, 1);
            chk($sformatf("t4_wdata_c%0d", i), mem_wdata, 32'h12345678);
            chk($sformatf("t4_noready_c%0d", i), dm_ready, 0);
        end
        @(negedge clk);
        chk("t4_dm_ready", dm_ready, 1);
        chk("t4_dm_rdata_kept", dm_rdata, 32'hA5A5A5A5);
        dm_req = 0;
        @(negedge clk);
        chk("t4_ready_once", dm_ready, 0);
        fixDelay = 0;

        // timeout on a fetch, then bus_err stays set
        memMode = 2;
        if_req = 1; if_addr = 32'h44;
        repeat (64) @(negedge clk);
        chk("t5_still_busy_c64", mem_req, 1);
        chk("t5_no_err_yet", bus_err, 0);
        chk("t5_no_ready_yet", if_ready, 0);
        @(negedge clk);
        chk("t5_if_ready", if_ready, 1);
        chk("t5_if_rdata_zero", if_rdata, 0);
        chk("t5_bus_err", bus_err, 1);
        chk("t5_mem_req_low", mem_req, 0);
        if_req = 0;
        memMode = 1;
        @(negedge clk);
        dm_req = 1; dm_we = 0; dm_addr = 32'h100;
        repeat (2) @(negedge clk);
        chk("t5_good_load", dm_rdata, 32'hA5A5A5A5);
        chk("t5_err_sticky", bus_err, 1);
        dm_req = 0;
        @(negedge clk);

        // reset while BUSY_DM, late ack ignored
        memMode = 2;
        dm_req = 1; dm_we = 0; dm_addr = 32'h100;
        @(negedge clk);
        chk("t6_busy", busy, 1);
        rst = 0; dm_req = 0;
        @(negedge clk);
        rst = 1;
        chk("t6_rst_outputs", {mem_req, mem_we, if_ready, dm_ready, bus_err, busy}, 0);
        chk("t6_rst_data", {mem_addr, mem_wdata, if_rdata, dm_rdata}, 0);
        @(negedge clk);
        forceAck = 1;
        @(negedge clk);
        forceAck = 0;
        @(negedge clk);
        chk("t6_no_dm_ready", dm_ready, 0);
        chk("t6_idle", busy, 0);
        chk("t6_mem_req", mem_req, 0);

        // randomized traffic
        memMode = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (if_req) begin
                if (if_ready) begin
                    if ($urandom_range(0, 1) == 0) if_req = 0;
                    else if_addr = $urandom;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = $urandom;
            end
            if (dm_req) begin
                if (dm_ready) begin
                    if ($urandom_range(0, 1) == 0) dm_req = 0;
                    else begin
                        dm_we = $urandom_range(0, 1); dm_addr = $urandom; dm_wdata = $urandom;
                    end
                end
            end else if ($urandom_range(0, 2) == 0) begin
                dm_req = 1; dm_we = $urandom_range(0, 1);
                dm_addr = $urandom; dm_wdata = $urandom;
            end
        end
        if_req = 0; dm_req = 0;
        repeat (80) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Arbitrates the fetch stage (IF) and memory stage (DM) of the 5-stage pipeline onto one shared single-port memory with a req/ack handshake.
- Sits between the pipeline's instruction and data ports and the unified memory.
- The pipeline stalls a stage while its request is pending and its ready has not pulsed.
- Provides fixed data priority with an anti-starvation limit, plus an ack timeout with a sticky error flag.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_DM_BURST, 4, max consecutive DM grants while IF is waiting; then IF is granted once.
- TIMEOUT_CYC, 64, cycles in a busy state without mem_ack before the transaction is aborted.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-low reset; sampled on the rising edge of clk.
- if_req  in  1  fetch request; held with if_addr until if_ready.
- if_addr  in  AW  fetch address.
- if_rdata  out  DW  fetched instruction; valid when if_ready=1.
- if_ready  out  1  one-cycle completion pulse for IF.
- dm_req  in  1  data request; held stable with dm_we, dm_addr and dm_wdata until dm_ready.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  store data.
- dm_rdata  out  DW  load data; valid when dm_ready=1.
- dm_ready  out  1  one-cycle completion pulse for DM.
- mem_req  out  1  request to the memory; held until mem_ack.
- mem_we  out  1  write enable to the memory.
- mem_addr  out  AW  latched address.
- mem_wdata  out  DW  latched write data.
- mem_rdata  in  DW  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion; may be asserted in the first cycle mem_req is high.
- busy  out  1  high when the state is not IDLE.
- bus_err  out  1  sticky; set on timeout, cleared only by reset.

Behaviour:
- Reset (rst=0 at a clock edge), including mid-transaction:
  - state=IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_ready, dm_ready, bus_err = 0.
  - starve_cnt = 0 and timeout counter = 0.
  - A mem_ack arriving after reset is ignored.
- All outputs are registered.
- States: IDLE, BUSY_IF, BUSY_DM.
- IDLE grant rule, evaluated each cycle:
  - Grant DM if dm_req && !(if_req && starve_cnt==MAX_DM_BURST).
  - Otherwise grant IF if if_req.
  - Otherwise stay in IDLE.
- On grant:
  - Latch addr, and for DM also we and wdata, into the mem_* registers.
  - Set mem_req=1 and go to the matching BUSY state.
  - mem_we=0 for IF grants.
- starve_cnt:
  - +1 on a DM grant while if_req=1, saturating at MAX_DM_BURST.
  - Cleared on an IF grant, or in any IDLE cycle with if_req=0.
- BUSY_x with mem_ack=1:
  - mem_req goes to 0.
  - x_ready pulses for one cycle.
  - For IF, and for DM loads, x_rdata <= mem_rdata.
  - DM stores leave dm_rdata unchanged.
  - Next state IDLE.
- Latency and throughput:
  - Request seen in cycle 0; mem_req high in cycle 1.
  - Ack in cycle k (k≥1) gives x_ready in cycle k+1.
  - Minimum 2-cycle latency.
  - One mandatory IDLE cycle between transactions.
  - The IDLE cycle after a ready pulse uses the requester's updated req.
- Timeout:
  - Counter increments each BUSY cycle without ack and clears on entering BUSY.
  - When it reaches TIMEOUT_CYC-1 with no ack: mem_req goes to 0, x_ready pulses with x_rdata=0 (for stores, dm_rdata is unchanged), bus_err is set to 1, next state IDLE.
  - mem_ack in the same cycle takes precedence over the timeout.
- mem_ack in IDLE is ignored.
- The non-granted requester receives no ready pulse and stays pending.
- Simultaneous if_req and dm_req in IDLE: DM wins unless starve_cnt==MAX_DM_BURST.
- Requests dropped mid-transaction (protocol violation) do not abort the in-flight memory access; the ready pulse is still issued.

Test Plan:
- Reset then IF fetch: if_req=1, if_addr=0x0, mem_ack in the first mem_req cycle returning 0x00500093 -> mem_req high in cycle 1, if_ready and if_rdata=0x00500093 in cycle 2, busy=0 in cycle 3.
- Collision: if_req=1 and dm_req=1 (load 0x100, returns 0xA5A5A5A5) in the same cycle -> DM granted first (mem_addr=0x100, mem_we=0), then IF after the IDLE cycle; dm_ready precedes if_ready.
- Starvation: dm_req held high with back-to-back stores, if_req held high, MAX_DM_BURST=4 -> exactly 4 DM grants, then 1 IF grant, then DM resumes.
- Store: dm_we=1, dm_addr=0x20, dm_wdata=0x12345678, ack delayed 3 cycles -> mem_we=1 and mem_wdata=0x12345678 held stable all 3 cycles; dm_ready pulses once; dm_rdata unchanged.
- Timeout: IF request with mem_ack never asserted, TIMEOUT_CYC=64 -> if_ready with if_rdata=0 after 64 BUSY cycles; bus_err=1 and stays 1 through later good transactions until rst=0.
- Reset mid-op: rst=0 while in BUSY_DM, then mem_ack=1 one cycle after reset is released -> all outputs 0, no dm_ready pulse, state IDLE.
